fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 88 ++++++++
 tb/tb_fifo_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops an upstream registered FIFO into a 2-entry output buffer with flush/drain.
// Optional FIFO_READER_STATS_EN adds a 16-bit pop_count output.
module fifo_reader #(
  parameter int D_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_pop,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef FIFO_READER_STATS_EN
  output logic [15:0]        pop_count,
`endif
  input  logic               flush
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [D_WIDTH-1:0] buf_head;
  logic [D_WIDTH-1:0] buf_tail;
  logic               capture;
  logic               transfer;

  // Pop depends only on registered state and the registered empty flag, never on out_ready.
  assign fifo_pop  = !rst && !fifo_empty && (state != FULL);
  assign capture   = fifo_pop && (state != DRAIN);
  assign out_valid = (state == ONE) || (state == FULL);
  assign transfer  = out_valid && out_ready;
  assign out_data  = buf_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      buf_head <= '0;
      buf_tail <= '0;
    end else if (flush) begin
      state    <= DRAIN;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            buf_head <= fifo_data;
            state    <= ONE;
          end
        end
        ONE: begin
          if (capture && transfer) begin
            buf_head <= fifo_data;
          end else if (capture) begin
            buf_tail <= fifo_data;
            state    <= FULL;
          end else if (transfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            buf_head <= buf_tail;
            state    <= ONE;
          end
        end
        DRAIN: begin
          if (fifo_empty) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) pop_count <= '0;
    else if (fifo_pop) pop_count <= pop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed and random checks of fifo_reader against an upstream FIFO model.
module tb_fifo_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] fifo_data = '0;
  logic       fifo_empty = 1'b1;
  logic       fifo_pop;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] pop_count;
`endif

  int checks = 0;
  int errors = 0;
  int npop = 0;
  logic [5:0] q[$];
  logic [5:0] got[$];
  logic [5:0] expq[$];

  fifo_reader #(.D_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FIFO_READER_STATS_EN
    .pop_count(pop_count),
`endif
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: registered head/empty, refreshed after each edge.
  always @(posedge clk) begin
    if (fifo_pop && q.size() > 0) void'(q.pop_front());
    if (fifo_pop) npop++;
    fifo_empty <= (q.size() == 0);
    fifo_data  <= (q.size() > 0) ? q[0] : 6'd0;
  end

  always @(posedge clk) begin
    if (!rst && !flush && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hDEAD;
  endfunction

  initial begin
    int n0;
    int gs;
    int mism;
    int pushed;
    int budget;
    logic [5:0] w;
    logic [5:0] t1_data [5] = '{6'h00, 6'h05, 6'h2A, 6'h11, 6'h00};
    logic       t1_pop  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       t1_val  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    tick(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    chk("rst_state", 32'(dut.state), 0);

    // Three words streamed at full rate.
    rst = 1'b0;
    out_ready = 1'b1;
    q.push_back(6'h05); q.push_back(6'h2A); q.push_back(6'h11);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("t1_pop%0d", i), 32'(fifo_pop), 32'(t1_pop[i]));
      chk($sformatf("t1_valid%0d", i), 32'(out_valid), 32'(t1_val[i]));
      if (t1_val[i]) chk($sformatf("t1_data%0d", i), 32'(out_data), 32'(t1_data[i]));
    end
    chk("t1_count", got.size(), 3);

    // Backpressure: only two pops until ready returns.
    out_ready = 1'b0;
    got.delete();
    n0 = npop;
    q.push_back(6'h01); q.push_back(6'h02); q.push_back(6'h03); q.push_back(6'h04);
    tick(6);
    chk("t2_pops", npop - n0, 2);
    chk("t2_state", 32'(dut.state), 2);
    chk("t2_pop_low", 32'(fifo_pop), 0);
    chk("t2_valid", 32'(out_valid), 1);
    tick(3);
    chk("t2_hold_data", 32'(out_data), 32'h01);
    chk("t2_hold_pops", npop - n0, 2);
    out_ready = 1'b1;
    tick(8);
    chk("t2_pops_all", npop - n0, 4);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), got_at(i), 32'(i + 1));
    chk("t2_state_end", 32'(dut.state), 0);

    // Flush a FULL buffer while the FIFO holds three words.
    out_ready = 1'b0;
    q.push_back(6'h3F); q.push_back(6'h01);
    tick(4);
    chk("t3_full", 32'(dut.state), 2);
    chk("t3_head", 32'(out_data), 32'h3F);
    q.push_back(6'h0A); q.push_back(6'h0B); q.push_back(6'h0C);
    tick(2);
    n0 = npop;
    gs = got.size();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    out_ready = 1'b1;
    chk("t3_valid", 32'(out_valid), 0);
    chk("t3_drain", 32'(dut.state), 3);
    chk("t3_drain_pop", 32'(fifo_pop), 1);
    tick(3);
    chk("t3_still_drain", 32'(dut.state), 3);
    chk("t3_data_clear", 32'(out_data), 0);
    tick(1);
    chk("t3_empty", 32'(dut.state), 0);
    chk("t3_pops", npop - n0, 3);
    chk("t3_no_out", got.size(), gs);

    // Flush coincident with a transfer: the word is not accepted.
    out_ready = 1'b0;
    q.push_back(6'h07);
    tick(3);
    chk("t4_one", 32'(dut.state), 1);
    chk("t4_data", 32'(out_data), 32'h07);
    gs = got.size();
    out_ready = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t4_not_taken", got.size(), gs);
    chk("t4_valid", 32'(out_valid), 0);
    tick(1);
    chk("t4_empty", 32'(dut.state), 0);

    // Reset while FULL with words still upstream.
    out_ready = 1'b0;
    q.push_back(6'h11); q.push_back(6'h12); q.push_back(6'h13); q.push_back(6'h14);
    tick(6);
    chk("t5_full", 32'(dut.state), 2);
    rst = 1'b1;
    tick(1);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_pop", 32'(fifo_pop), 0);
    chk("t5_state", 32'(dut.state), 0);
`ifdef FIFO_READER_STATS_EN
    chk("t5_pop_count", 32'(pop_count), 0);
`endif
    rst = 1'b0;
    got.delete();
    out_ready = 1'b1;
    tick(6);
    chk("t5_count", got.size(), 2);
    chk("t5_word0", got_at(0), 32'h13);
    chk("t5_word1", got_at(1), 32'h14);

    // Random stream against an in-order model.
    got.delete();
    expq.delete();
    pushed = 0;
    budget = 0;
    while ((pushed < 1000 || got.size() < 1000) && budget < 20000) begin
      if (pushed < 1000 && ($urandom % 4) != 0) begin
        w = 6'($urandom);
        q.push_back(w);
        expq.push_back(w);
        pushed++;
      end
      out_ready = (($urandom % 3) != 0);
      tick(1);
      budget++;
    end
    chk("t6_budget", 32'(budget < 20000), 1);
    chk("t6_count", got.size(), 1000);
    mism = 0;
    for (int i = 0; i < 1000; i++)
      if (got_at(i) !== 32'(expq[i])) mism++;
    chk("t6_order", mism, 0);

`ifdef FIFO_READER_STATS_EN
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("t7_zero", 32'(pop_count), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) q.push_back(6'(i));
    tick(65537 + 8);
    chk("t7_wrap", 32'(pop_count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
